sample_buf_ctrl: RTL and testbench
==================================

SAMPLE_BUF_CTRL -- requirements
Module: sample_buf_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 8: buffer RAM address width; depth D = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 12: sample width.
REQ-003 clk  in  1  sole clock; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  begin capture; sampled only in IDLE.
REQ-006 abort  in  1  synchronous return to IDLE from any state.
REQ-007 capture_len  in  ADDR_WIDTH+1  sample count, latched on accepted start.
REQ-008 in_valid  in  1  qualifies in_data.
REQ-009 in_data  in  DATA_WIDTH  input sample.
REQ-010 ram_wr_en  out  1  RAM write strobe.
REQ-011 ram_wr_addr  out  ADDR_WIDTH  RAM write address.
REQ-012 ram_wr_data  out  DATA_WIDTH  RAM write data.
REQ-013 ram_rd_addr  out  ADDR_WIDTH  RAM read address, registered.
REQ-014 ram_rd_data  in  DATA_WIDTH  RAM read data, valid one cycle after ram_rd_addr is presented.
REQ-015 out_valid / out_ready / out_data[DATA_WIDTH-1:0] / out_last  out/in/out/out  readout stream.
REQ-016 busy  out  1  high in any state other than IDLE.
REQ-017 done  out  1  one-cycle pulse on readout completion.

Function
REQ-018 States IDLE, CAPTURE, READ; encoding free.
REQ-019 IDLE: start=1 latches L = min(capture_len, D), clears write and read counters; next state CAPTURE if L>0; if L=0, stay IDLE and pulse done next cycle, with no RAM writes.
REQ-020 CAPTURE: ram_wr_en = in_valid (combinational), ram_wr_data = in_data, ram_wr_addr = write counter; the counter increments on each write.
REQ-021 CAPTURE -> READ on the clock edge that performs write L; in_valid is ignored in every state except CAPTURE.
REQ-022 READ: a read is issued (ram_rd_addr advances) only if (output buffer occupancy + reads in flight) < 2 and issued count < L.
REQ-023 Returned read data enters a 2-entry output FIFO; out_valid = FIFO non-empty; out_data = FIFO head.
REQ-024 A handshake occurs when out_valid && out_ready; out_data and out_last stay stable while out_valid && !out_ready.
REQ-025 out_last = 1 only with sample index L-1 (samples indexed 0..L-1, in write order).
REQ-026 First out_valid occurs no later than 2 cycles after entering READ.
REQ-027 With out_ready held at 1, READ sustains one sample per cycle.
REQ-028 The handshake of the last sample ends READ; the next state is IDLE and done=1 for exactly the following cycle.
REQ-029 start while busy is ignored; start in the same cycle as abort is ignored.
REQ-030 abort=1: next state IDLE, FIFO flushed, in-flight read discarded, counters cleared, no done pulse; ram_wr_en is forced to 0 in the abort cycle.
REQ-031 L=D fills every address; the write counter wraps to 0 and must not corrupt the transition to READ.
REQ-032 The first read after the last write targets an address already written one or more cycles earlier; no read-during-write hazard to address.

Reset
REQ-033 rst_n=0 forces IDLE immediately; out_valid, out_last, busy, done, and ram_wr_en are 0; ram_rd_addr, ram_wr_addr, counters, and FIFO are cleared.
REQ-034 Reset mid-CAPTURE or mid-READ behaves identically to REQ-033; no done pulse is produced.

Verification
REQ-035 start, capture_len=4, in_data 1,2,3,4 on consecutive cycles, out_ready=1 -> writes at addresses 0..3; out_data 1,2,3,4 on consecutive cycles; out_last with 4; done one cycle later.
REQ-036 capture_len=D (256), random in_valid gaps -> exactly 256 writes; readout matches in order; out_last only on the 256th sample.
REQ-037 L=8, out_ready toggled 1,0,0,1,... -> no sample lost or duplicated; data stable while stalled; at most 2 outstanding reads.
REQ-038 capture_len=0 -> no ram_wr_en; busy stays 0; done pulses once.
REQ-039 abort at 3rd sample of CAPTURE, then new start with L=2 -> clean capture and readout of the 2 new samples only; no done for the aborted run.
REQ-040 rst_n asserted mid-READ with out_valid=1 -> out_valid=0 immediately; after release, IDLE with busy=0.

Source files
------------

// File: rtl/sample_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sample_buf_ctrl
//  Purpose  : Captures a burst of input samples into an external buffer RAM,
//             then streams them back out through a ready/valid interface.
//             The RAM has a one-cycle read latency, and a 2-entry skid FIFO
//             absorbs that latency.
//  Revision : 1.0  initial release
// ============================================================================
module sample_buf_ctrl #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   capture_len,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_CAPTURE = 2'd1;
    localparam logic [1:0] S_READ    = 2'd2;

    localparam logic [ADDR_WIDTH:0] C_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] C_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            r_state;
    logic [1:0]            w_next_state;
    logic [ADDR_WIDTH:0]   r_len;
    logic [ADDR_WIDTH:0]   r_wr_cnt;
    logic [ADDR_WIDTH:0]   r_rd_cnt;
    logic                  r_inflight;
    logic                  r_inflight_last;
    logic [DATA_WIDTH-1:0] r_fifo_data [0:1];
    logic [1:0]            r_fifo_last;
    logic                  r_head;
    logic [1:0]            r_count;
    logic                  r_done;

    logic [ADDR_WIDTH:0]   w_len_sat;
    logic                  w_len_zero;
    logic                  w_start_ok;
    logic                  w_wr;
    logic [ADDR_WIDTH:0]   w_wr_cnt_inc;
    logic [ADDR_WIDTH:0]   w_rd_cnt_inc;
    logic                  w_last_wr;
    logic                  w_pop;
    logic                  w_final_pop;
    logic [1:0]            w_occ;
    logic                  w_issue;
    logic                  w_tail;

    assign w_len_sat    = (capture_len > C_DEPTH) ? C_DEPTH : capture_len;
    assign w_len_zero   = (capture_len == '0);
    assign w_start_ok   = (r_state == S_IDLE) && start && !abort;
    assign w_wr         = (r_state == S_CAPTURE) && in_valid && !abort;
    assign w_wr_cnt_inc = r_wr_cnt + C_ONE;
    assign w_rd_cnt_inc = r_rd_cnt + C_ONE;
    assign w_last_wr    = w_wr && (w_wr_cnt_inc == r_len);
    assign w_pop        = out_valid && out_ready;
    assign w_final_pop  = w_pop && r_fifo_last[r_head] && (r_state == S_READ);
    // Occupancy counts the head as already gone when it is handed off this
    // cycle, which lets a new read issue each cycle under full throughput
    // while the FIFO + in-flight total still never exceeds two entries.
    assign w_occ        = r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    assign w_issue      = (r_state == S_READ) && !abort && (w_occ < 2'd2) &&
                          (r_rd_cnt < r_len);
    assign w_tail       = r_head ^ r_count[0];

    assign ram_wr_en    = w_wr;
    assign ram_wr_addr  = r_wr_cnt[ADDR_WIDTH-1:0];
    assign ram_wr_data  = in_data;
    assign ram_rd_addr  = r_rd_cnt[ADDR_WIDTH-1:0];
    assign out_valid    = (r_count != 2'd0);
    assign out_data     = r_fifo_data[r_head];
    assign out_last     = out_valid && r_fifo_last[r_head];
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        w_next_state = r_state;
        if (abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:    if (start && !w_len_zero) w_next_state = S_CAPTURE;
                S_CAPTURE: if (w_last_wr)            w_next_state = S_READ;
                S_READ:    if (w_final_pop)          w_next_state = S_IDLE;
                default:                             w_next_state = S_IDLE;
            endcase
        end
    end

    // Counters, read pipeline, output FIFO and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_len           <= '0;
            r_wr_cnt        <= '0;
            r_rd_cnt        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_data[0]  <= '0;
            r_fifo_data[1]  <= '0;
            r_fifo_last     <= 2'b00;
            r_head          <= 1'b0;
            r_count         <= 2'd0;
            r_done          <= 1'b0;
        end else if (abort) begin
            r_wr_cnt        <= '0;
            r_rd_cnt        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_head          <= 1'b0;
            r_count         <= 2'd0;
            r_done          <= 1'b0;
        end else begin
            r_done <= w_final_pop || (w_start_ok && w_len_zero);
            if (w_start_ok) begin
                r_len    <= w_len_sat;
                r_wr_cnt <= '0;
                r_rd_cnt <= '0;
            end else begin
                if (w_wr)    r_wr_cnt <= w_wr_cnt_inc;
                if (w_issue) r_rd_cnt <= w_rd_cnt_inc;
            end
            // The RAM returns data the cycle after the address is presented.
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (w_rd_cnt_inc == r_len);
            if (r_inflight) begin
                r_fifo_data[w_tail] <= ram_rd_data;
                r_fifo_last[w_tail] <= r_inflight_last;
            end
            if (w_pop) r_head <= ~r_head;
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sample_buf_ctrl
//  Purpose  : Self-checking bench for sample_buf_ctrl with a behavioural RAM
//             and a sample-order reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_sample_buf_ctrl;
    localparam int AW = 8;
    localparam int DW = 12;
    localparam int D  = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n, start, abort, in_valid, out_ready;
    logic [AW:0]   capture_len;
    logic [DW-1:0] in_data, ram_wr_data, ram_rd_data, out_data;
    logic [AW-1:0] ram_wr_addr, ram_rd_addr;
    logic          ram_wr_en, out_valid, out_last, busy, done;

    int checks = 0, errors = 0, cyc = 0;

    logic [DW-1:0] mem [0:D-1];
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    logic [DW-1:0] out_data_q[$];
    logic          out_last_q[$];
    int            out_cyc_q[$];
    int  done_cnt = 0, done_cyc = 0, issues = 0, pops = 0, max_out = 0;
    int  first_ov_cyc = -1, last_wr_cyc = 0, stall_err = 0;
    bit  busy_seen = 0, prev_busy = 0, hold_valid = 0, timed_out = 0;
    logic [AW-1:0] prev_rd_addr = '0;
    logic [DW-1:0] hold_data = '0;
    logic          hold_last = 1'b0;

    sample_buf_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .capture_len(capture_len), .in_valid(in_valid), .in_data(in_data),
        .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
        .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM with one-cycle read latency (read returns old data on collision).
    always @(posedge clk) begin
        if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
        ram_rd_data <= mem[ram_rd_addr];
    end

    // Observe mid-cycle: log writes, handshakes, done pulses, stalls and outstanding reads.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_valid = 1'b0;
        end else begin
            if (ram_wr_en) begin
                wr_addr_q.push_back(ram_wr_addr);
                wr_data_q.push_back(ram_wr_data);
                last_wr_cyc = cyc;
            end
            if (busy) busy_seen = 1'b1;
            if (busy && prev_busy && ram_rd_addr != prev_rd_addr) issues++;
            if (issues - pops > max_out) max_out = issues - pops;
            if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc;
            if (hold_valid && (!out_valid || out_data !== hold_data || out_last !== hold_last))
                stall_err++;
            hold_valid = out_valid && !out_ready;
            hold_data  = out_data;
            hold_last  = out_last;
            if (out_valid && out_ready) begin
                out_data_q.push_back(out_data);
                out_last_q.push_back(out_last);
                out_cyc_q.push_back(cyc);
                pops++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_busy    = busy;
        prev_rd_addr = ram_rd_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        exp_q.delete(); wr_addr_q.delete(); wr_data_q.delete();
        out_data_q.delete(); out_last_q.delete(); out_cyc_q.delete();
        issues = 0; pops = 0; max_out = 0; first_ov_cyc = -1;
        stall_err = 0; busy_seen = 1'b0; timed_out = 1'b0;
    endtask

    // Drives one capture/readout run; the model is the list of accepted samples.
    // rmode: 0 ready always, 1 ready pattern 1,0,0 repeating, 2 random ready.
    task automatic drive_run(input int cl, input int vprob, input int rmode,
                             input bit seq, input bit poke);
        int L, sent, t, d0, budget;
        L = (cl > D) ? D : cl;
        sent = 0; t = 0; d0 = done_cnt; budget = 6 * L + 60;
        clear_logs();
        start = 1'b1; capture_len = (AW+1)'(cl);
        tick();
        start = 1'b0;
        while (done_cnt == d0 && t < budget) begin
            if (sent < L) begin
                in_valid = ($urandom_range(0, 99) < vprob);
                in_data  = seq ? DW'(sent + 1) : DW'($urandom);
                if (in_valid) begin
                    exp_q.push_back(in_data);
                    sent++;
                end
            end else begin
                in_valid = 1'($urandom_range(0, 1));
                in_data  = DW'($urandom);
            end
            out_ready   = (rmode == 0) ? 1'b1 : (rmode == 1) ? (t % 3 == 0) : 1'($urandom_range(0, 1));
            start       = poke ? (busy && $urandom_range(0, 3) == 0) : 1'b0;
            capture_len = (AW+1)'($urandom_range(0, 2 * D - 1));
            tick();
            t++;
        end
        timed_out = (done_cnt == d0);
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; abort = 1'b0; capture_len = '0;
        in_valid = 1'b1; in_data = '0; out_ready = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b/%b want 0/0", busy, done); end
        checks++; if (ram_wr_en !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_wr_en_last: got %b/%b want 0/0", ram_wr_en, out_last); end
        checks++; if (ram_rd_addr !== '0 || ram_wr_addr !== '0) begin errors++; $display("FAIL reset_addr: got %0h/%0h want 0/0", ram_rd_addr, ram_wr_addr); end
        tick(); tick();
        rst_n = 1'b1; in_valid = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        int d0;
        d0 = done_cnt;
        drive_run(4, 100, 0, 1'b1, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: no done within budget"); end
        checks++; if (wr_addr_q.size() != 4) begin errors++; $display("FAIL basic_wr_count: got %0d want 4", wr_addr_q.size()); end
        for (int i = 0; i < wr_addr_q.size() && i < 4; i++) begin
            checks++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== DW'(i + 1)) begin
                errors++; $display("FAIL basic_write[%0d]: got addr %0h data %0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i], i, i + 1); end
        end
        checks++; if (out_data_q.size() != 4) begin errors++; $display("FAIL basic_out_count: got %0d want 4", out_data_q.size()); end
        for (int i = 0; i < out_data_q.size() && i < 4; i++) begin
            checks++; if (out_data_q[i] !== DW'(i + 1) || out_last_q[i] !== (i == 3) || out_cyc_q[i] != out_cyc_q[0] + i) begin
                errors++; $display("FAIL basic_out[%0d]: got data %0h last %b cyc %0d want %0h/%b/%0d", i, out_data_q[i], out_last_q[i], out_cyc_q[i], i + 1, i == 3, out_cyc_q[0] + i); end
        end
        if (out_cyc_q.size() == 4) begin
            checks++; if (done_cyc != out_cyc_q[3] + 1) begin errors++; $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc, out_cyc_q[3] + 1); end
        end
        checks++; if (first_ov_cyc < 0 || first_ov_cyc > last_wr_cyc + 3) begin errors++; $display("FAIL basic_first_valid: got cyc %0d want <= %0d", first_ov_cyc, last_wr_cyc + 3); end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_full_depth();
        int d0;
        d0 = done_cnt;
        drive_run(D, 70, 2, 1'b0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL full_timeout: no done within budget"); end
        checks++; if (wr_addr_q.size() != D) begin errors++; $display("FAIL full_wr_count: got %0d want %0d", wr_addr_q.size(), D); end
        for (int i = 0; i < wr_addr_q.size() && i < exp_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL full_write[%0d]: got %0h/%0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]); end
        end
        checks++; if (out_data_q.size() != D) begin errors++; $display("FAIL full_out_count: got %0d want %0d", out_data_q.size(), D); end
        for (int i = 0; i < out_data_q.size() && i < exp_q.size(); i++) begin
            checks++; if (out_data_q[i] !== exp_q[i] || out_last_q[i] !== (i == D - 1)) begin
                errors++; $display("FAIL full_out[%0d]: got %0h last %b want %0h last %b", i, out_data_q[i], out_last_q[i], exp_q[i], i == D - 1); end
        end
        checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL full_done: got %0d pulses busy %b want 1/0", done_cnt - d0, busy); end
        checks++; if (stall_err != 0 || max_out > 2) begin errors++; $display("FAIL full_flow: got stall %0d outstanding %0d want 0/<=2", stall_err, max_out); end
    endtask

    task automatic test_backpressure();
        drive_run(8, 100, 1, 1'b0, 1'b0);
        checks++; if (timed_out) begin errors++; $display("FAIL bp_timeout: no done within budget"); end
        checks++; if (out_data_q.size() != 8) begin errors++; $display("FAIL bp_out_count: got %0d want 8", out_data_q.size()); end
        for (int i = 0; i < out_data_q.size() && i < exp_q.size(); i++) begin
            checks++; if (out_data_q[i] !== exp_q[i] || out_last_q[i] !== (i == 7)) begin
                errors++; $display("FAIL bp_out[%0d]: got %0h last %b want %0h last %b", i, out_data_q[i], out_last_q[i], exp_q[i], i == 7); end
        end
        checks++; if (stall_err != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_err); end
        checks++; if (max_out > 2) begin errors++; $display("FAIL bp_outstanding: got %0d want <= 2", max_out); end
    endtask

    task automatic test_zero_len();
        int d0, sc;
        d0 = done_cnt;
        clear_logs();
        start = 1'b1; capture_len = '0; in_valid = 1'b1; sc = cyc;
        tick();
        start = 1'b0; in_valid = 1'b0;
        tick(); tick(); tick();
        checks++; if (wr_addr_q.size() != 0) begin errors++; $display("FAIL zero_writes: got %0d want 0", wr_addr_q.size()); end
        checks++; if (busy_seen) begin errors++; $display("FAIL zero_busy: got busy=1 want 0"); end
        checks++; if (done_cnt - d0 != 1 || done_cyc != sc + 1) begin errors++; $display("FAIL zero_done: got %0d pulses at %0d want 1 at %0d", done_cnt - d0, done_cyc, sc + 1); end
        // start coinciding with abort in IDLE must be ignored
        d0 = done_cnt;
        clear_logs();
        start = 1'b1; abort = 1'b1; capture_len = 9'd5;
        tick();
        start = 1'b0; abort = 1'b0;
        tick(); tick(); tick();
        checks++; if (busy_seen || done_cnt != d0) begin errors++; $display("FAIL start_abort_ignored: got busy_seen %b done %0d want 0/0", busy_seen, done_cnt - d0); end
    endtask

    task automatic test_abort();
        int d0;
        d0 = done_cnt;
        clear_logs();
        start = 1'b1; capture_len = 9'd6;
        tick();
        start = 1'b0; in_valid = 1'b1; in_data = 12'd11;
        tick();
        in_data = 12'd12;
        tick();
        in_data = 12'd13; abort = 1'b1;
        #1;
        checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL abort_wr_en: got %b want 0", ram_wr_en); end
        tick();
        abort = 1'b0; in_valid = 1'b0;
        tick(); tick();
        checks++; if (wr_addr_q.size() != 2 || busy !== 1'b0) begin errors++; $display("FAIL abort_state: got %0d writes busy %b want 2/0", wr_addr_q.size(), busy); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL abort_no_done: got %0d pulses want 0", done_cnt - d0); end
        d0 = done_cnt;
        drive_run(2, 100, 0, 1'b0, 1'b0);
        checks++; if (timed_out || wr_addr_q.size() != 2) begin errors++; $display("FAIL abort_rerun_writes: got %0d (timeout %b) want 2", wr_addr_q.size(), timed_out); end
        for (int i = 0; i < wr_addr_q.size() && i < exp_q.size(); i++) begin
            checks++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_q[i]) begin
                errors++; $display("FAIL abort_rerun_write[%0d]: got %0h/%0h want %0h/%0h", i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]); end
        end
        checks++; if (out_data_q.size() != 2) begin errors++; $display("FAIL abort_rerun_out_count: got %0d want 2", out_data_q.size()); end
        for (int i = 0; i < out_data_q.size() && i < exp_q.size(); i++) begin
            checks++; if (out_data_q[i] !== exp_q[i] || out_last_q[i] !== (i == 1)) begin
                errors++; $display("FAIL abort_rerun_out[%0d]: got %0h last %b want %0h last %b", i, out_data_q[i], out_last_q[i], exp_q[i], i == 1); end
        end
        checks++; if (done_cnt - d0 != 1) begin errors++; $display("FAIL abort_rerun_done: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_random();
        int cl, L, d0;
        for (int r = 0; r < 5; r++) begin
            cl = (r == 0) ? 300 : $urandom_range(1, 40);
            L  = (cl > D) ? D : cl;
            d0 = done_cnt;
            drive_run(cl, $urandom_range(30, 100), 2, 1'b0, 1'b1);
            checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout: no done within budget", r); end
            checks++; if (wr_addr_q.size() != L || out_data_q.size() != L) begin
                errors++; $display("FAIL rand%0d_count: got %0d writes %0d outputs want %0d", r, wr_addr_q.size(), out_data_q.size(), L); end
            for (int i = 0; i < wr_addr_q.size() && i < exp_q.size(); i++) begin
                checks++; if (wr_addr_q[i] !== AW'(i) || wr_data_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL rand%0d_write[%0d]: got %0h/%0h want %0h/%0h", r, i, wr_addr_q[i], wr_data_q[i], i, exp_q[i]); end
            end
            for (int i = 0; i < out_data_q.size() && i < exp_q.size(); i++) begin
                checks++; if (out_data_q[i] !== exp_q[i] || out_last_q[i] !== (i == L - 1)) begin
                    errors++; $display("FAIL rand%0d_out[%0d]: got %0h last %b want %0h last %b", r, i, out_data_q[i], out_last_q[i], exp_q[i], i == L - 1); end
            end
            checks++; if (done_cnt - d0 != 1 || busy !== 1'b0) begin errors++; $display("FAIL rand%0d_done: got %0d pulses busy %b want 1/0", r, done_cnt - d0, busy); end
            checks++; if (stall_err != 0 || max_out > 2) begin errors++; $display("FAIL rand%0d_flow: got stall %0d outstanding %0d want 0/<=2", r, stall_err, max_out); end
        end
    endtask

    task automatic test_reset_mid_read();
        int d0, t;
        d0 = done_cnt;
        clear_logs();
        out_ready = 1'b0; start = 1'b1; capture_len = 9'd8;
        tick();
        start = 1'b0; in_valid = 1'b1; t = 0;
        while (!out_valid && t < 60) begin
            in_data = DW'($urandom);
            tick();
            t++;
        end
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstread_reach: got out_valid %b want 1", out_valid); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0 || out_last !== 1'b0) begin errors++; $display("FAIL rstread_out: got %b/%b want 0/0", out_valid, out_last); end
        checks++; if (busy !== 1'b0 || ram_rd_addr !== '0 || ram_wr_addr !== '0) begin errors++; $display("FAIL rstread_state: got busy %b rd %0h wr %0h want 0/0/0", busy, ram_rd_addr, ram_wr_addr); end
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick(); tick();
        checks++; if (busy !== 1'b0 || out_valid !== 1'b0) begin errors++; $display("FAIL rstread_after: got busy %b valid %b want 0/0", busy, out_valid); end
        checks++; if (done_cnt != d0) begin errors++; $display("FAIL rstread_no_done: got %0d pulses want 0", done_cnt - d0); end
    endtask

    initial begin
        for (int i = 0; i < D; i++) mem[i] = '0;
        test_reset();
        test_basic();
        test_full_depth();
        test_backpressure();
        test_zero_len();
        test_abort();
        test_random();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
